// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command front-end and execution stage of the 16-bit ALU.
// Single-cycle add/sub/logic/shift, iterative multiply and restoring divide.
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             abort,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_error,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL,
    DIV,
    DONE
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  localparam int SH_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(WIDTH);

  state_t state;
  state_t state_nxt;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic               load;
  logic               finish;
  logic [WIDTH-1:0]   res_nxt;
  logic               err_nxt;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH-1:0]   exec_res;
  logic               exec_err;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // One shift-and-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
              + (acc[0] ? {1'b0, a_q} : '0);
    mul_step  = {mul_sum, acc[WIDTH-1:1]};
    div_trial = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, b_q};
    if (div_diff[WIDTH])
      div_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Single-cycle result and error for the latched operation.
  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
    unique case (1'b1)
      (op_q == OP_ADD): {exec_err, exec_res} = {1'b0, a_q} + {1'b0, b_q};
      (op_q == OP_SUB): begin
        exec_res = a_q - b_q;
        exec_err = (a_q < b_q);
      end
      (op_q == OP_AND): exec_res = a_q & b_q;
      (op_q == OP_OR):  exec_res = a_q | b_q;
      (op_q == OP_XOR): exec_res = a_q ^ b_q;
      (op_q == OP_SHL): begin
        exec_res = a_q << b_q[SH_W-1:0];
        exec_err = |b_q[WIDTH-1:SH_W];
      end
      (op_q == OP_DIV): begin
        exec_res = '1;
        exec_err = 1'b1;
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, operand load and result capture strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    res_nxt   = '0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          load = 1'b1;
          if (cmd_op == OP_MUL)
            state_nxt = MUL;
          else if (cmd_op == OP_DIV && cmd_b != '0)
            state_nxt = DIV;
          else
            state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          finish    = 1'b1;
          res_nxt   = exec_res;
          err_nxt   = exec_err;
          state_nxt = DONE;
        end
      end
      MUL: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          finish    = 1'b1;
          res_nxt   = mul_step[WIDTH-1:0];
          err_nxt   = |mul_step[2*WIDTH-1:WIDTH];
          state_nxt = DONE;
        end
      end
      DIV: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == LAST) begin
          finish    = 1'b1;
          res_nxt   = div_step[WIDTH-1:0];
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration register and saturating counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (load) begin
      op_q <= cmd_op;
      a_q  <= cmd_a;
      b_q  <= cmd_b;
      cnt  <= '0;
      if (cmd_op == OP_DIV)
        acc <= {{WIDTH{1'b0}}, cmd_a};
      else
        acc <= {{WIDTH{1'b0}}, cmd_b};
    end else if (state == MUL || state == DIV) begin
      acc <= (state == MUL) ? mul_step : div_step;
      if (cnt != MAXC)
        cnt <= cnt + CNT_W'(1);
    end
  end

  // Result registers update entering DONE; valid pulses while leaving it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_data  <= '0;
      res_error <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= (state == DONE);
      if (finish) begin
        res_data  <= res_nxt;
        res_error <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random checks of alu_op_sequencer
// against an arithmetic reference model.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic        abort = 1'b0;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_error;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  alu_op_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_a(cmd_a),
    .cmd_b(cmd_b),
    .abort(abort),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_error(res_error),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Returns {error, result}.
  function automatic logic [16:0] ref_op(input logic [2:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] s;
    logic [31:0] p;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; return s; end
      3'd1: return {(a < b), 16'(a - b)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {(b > 16'd15), 16'(a << (b % 16))};
      3'd6: begin
        p = 32'(a) * 32'(b);
        return {(p > 32'hFFFF), p[15:0]};
      end
      default: begin
        if (b == 0) return {1'b1, 16'hFFFF};
        return {1'b0, 16'(a / b)};
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [15:0] b);
    if (op == 3'd6 || (op == 3'd7 && b != 0)) return 17;
    return 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b);
    logic [16:0] e;
    int lat;
    int k;
    int bc;
    bit got;
    e = ref_op(op, a, b);
    lat = ref_lat(op, b);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    k = 0;
    while (!cmd_ready && k < 40) begin
      @(negedge clock);
      k++;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    check($sformatf("ready_drop op%0d", op), cmd_ready, 0);
    bc = busy ? 1 : 0;
    got = 0;
    for (k = 1; k <= lat + 2; k++) begin
      @(posedge clock);
      #1;
      if (res_valid) begin
        got = 1;
        break;
      end
      if (busy) bc++;
    end
    check($sformatf("latency op%0d %h,%h", op, a, b), got ? k : -1, lat);
    check($sformatf("data op%0d %h,%h", op, a, b), res_data, e[15:0]);
    check($sformatf("error op%0d %h,%h", op, a, b), res_error, e[16]);
    check($sformatf("busy_cycles op%0d", op), bc, lat);
    @(posedge clock);
    #1;
    check("pulse_width", res_valid, 0);
  endtask

  initial begin
    int pulses;
    logic [2:0] rop;
    logic [15:0] ra;
    logic [15:0] rb;

    #12;
    check("reset res_valid", res_valid, 0);
    check("reset res_data", res_data, 0);
    check("reset res_error", res_error, 0);
    check("reset busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("ready after reset", cmd_ready, 1);

    run_op(3'd0, 16'h7FFF, 16'h0001);
    run_op(3'd0, 16'hFFFF, 16'h0001);
    run_op(3'd1, 16'h0003, 16'h0005);
    run_op(3'd4, 16'hF0F0, 16'h0FF0);
    run_op(3'd5, 16'h0001, 16'h0004);
    run_op(3'd5, 16'h0001, 16'h0010);
    run_op(3'd2, 16'hF0F0, 16'h3C3C);
    run_op(3'd3, 16'hF000, 16'h000F);
    run_op(3'd6, 16'd300, 16'd200);
    run_op(3'd6, 16'h0100, 16'h0100);
    run_op(3'd7, 16'd5, 16'd0);
    run_op(3'd7, 16'hFFFF, 16'h0001);
    run_op(3'd7, 16'd1000, 16'd7);

    // Abort in the fifth MUL cycle.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = 3'd6;
    cmd_a = 16'd3;
    cmd_b = 16'd4;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    check("abort accepted", busy, 1);
    repeat (4) @(posedge clock);
    @(negedge clock);
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    check("abort busy", busy, 0);
    check("abort ready", cmd_ready, 1);
    check("abort data", res_data, 16'h008E);
    check("abort error", res_error, 0);
    pulses = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (res_valid) pulses++;
    end
    check("abort no pulse", pulses, 0);

    // Command held during busy is ignored until ready returns.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = 3'd0;
    cmd_a = 16'h1234;
    cmd_b = 16'h1111;
    @(posedge clock);
    #1;
    cmd_op = 3'd4;
    cmd_a = 16'hAAAA;
    cmd_b = 16'h5555;
    @(posedge clock);
    #1;
    check("hold e1 valid", res_valid, 0);
    @(posedge clock);
    #1;
    check("hold e2 valid", res_valid, 1);
    check("hold e2 data", res_data, 16'h2345);
    check("hold e2 ready", cmd_ready, 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    check("hold e3 accept", cmd_ready, 0);
    check("hold e3 valid", res_valid, 0);
    @(posedge clock);
    #1;
    check("hold e4 valid", res_valid, 0);
    @(posedge clock);
    #1;
    check("hold e5 valid", res_valid, 1);
    check("hold e5 data", res_data, 16'hFFFF);
    check("hold e5 error", res_error, 0);

    // Asynchronous reset mid-DIV.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op = 3'd7;
    cmd_a = 16'd1000;
    cmd_b = 16'd7;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("mid reset data", res_data, 0);
    check("mid reset error", res_error, 0);
    check("mid reset busy", busy, 0);
    check("mid reset valid", res_valid, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("post reset ready", cmd_ready, 1);
    run_op(3'd0, 16'd1, 16'd1);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(0, 20));
      run_op(rop, ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command front-end and multi-cycle execution stage of the 16-bit ALU.
- Accepts one operation (opcode plus two operands) over a valid/ready handshake.
- Executes it in 1 cycle (add/sub/logic/shift) or 16 iterations (unsigned multiply, restoring divide).
- Presents result, error and busy status for one-pulse capture by the downstream 16-bit result, error and running flag registers.

Parameters:
- WIDTH, 16, operand/result width; the iteration count equals WIDTH.
- CNT_W, 5, iteration counter width; must hold values 0..WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept; high only in IDLE.
- cmd_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 DIV.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- abort  in  1  synchronous cancel of the in-flight operation.
- res_valid  out  1  one-cycle pulse; res_data and res_error are valid.
- res_data  out  WIDTH  result; holds its value between pulses.
- res_error  out  1  error flag for the current result; holds its value between pulses.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, counter=0, operand/partial registers=0.
  - res_valid=0, res_data=0, res_error=0, busy=0.
  - cmd_ready=1 once reset is deasserted.
- States: IDLE, EXEC, MUL, DIV, DONE.
- Accept: cmd_valid & cmd_ready at a rising edge. Latch op, A and B.
  - MUL goes to MUL, counter cleared.
  - DIV with B≠0 goes to DIV, counter cleared.
  - All other ops, including DIV with B=0, go to EXEC.
- cmd_valid while not in IDLE is ignored; no queuing, and the command is not latched.
- EXEC (one cycle), then DONE:
  - ADD: res = A+B mod 2^16; error = carry out.
  - SUB: res = A−B mod 2^16; error = borrow (A<B).
  - AND/OR/XOR: bitwise; error=0.
  - SHL: res = A << B[3:0]; error=1 if B[15:4]≠0 (the result is still the 4-bit-amount shift).
  - DIV with B=0: res=0xFFFF, error=1.
- MUL: shift-and-add over a 2·WIDTH product register, one multiplier bit per cycle.
  - After counter reaches WIDTH (16 MUL cycles), go to DONE.
  - res = product[15:0]; error = (product[31:16] ≠ 0).
- DIV: restoring division, one quotient bit per cycle, 16 cycles, then DONE.
  - res = quotient (unsigned); error=0; remainder is discarded.
- DONE (one cycle):
  - res_valid=1; res_data and res_error are updated on the edge entering DONE.
  - Next state is IDLE.
- Latency, counted from the accept edge to the edge at which res_valid rises:
  - 2 cycles for EXEC ops.
  - 17 cycles for MUL and for DIV with B≠0.
- Throughput: the next command is accepted at the earliest on the edge after DONE.
  - Back-to-back single-cycle ops therefore occur every 3 cycles.
- abort:
  - Sampled in EXEC, MUL or DIV: next state is IDLE.
  - No res_valid is produced; res_data and res_error keep their previous values.
  - abort in IDLE or DONE has no effect; DONE still completes.
- Reset mid-operation: immediate return to IDLE; any partial result is lost.
- The counter saturates at WIDTH; the state change on the WIDTH-th iteration prevents wrap.
- No X propagation: res_data and res_error change only on the edge entering DONE, or on reset.

Test Plan:
- Reset, then ADD A=0x7FFF B=0x0001 → cmd_ready drops; res_valid 2 cycles after accept; res_data=0x8000, res_error=0. ADD 0xFFFF+0x0001 → 0x0000, res_error=1.
- SUB 0x0003−0x0005 → 0xFFFE, error=1. XOR 0xF0F0^0x0FF0 → 0xFF00, error=0. SHL 0x0001 by 0x0004 → 0x0010, error=0. SHL by 0x0010 → 0x0001, error=1.
- MUL 300×200 → res_valid at accept+17, 0xEA60, error=0, busy high 16 cycles of MUL. MUL 0x0100×0x0100 → 0x0000, error=1.
- DIV 1000/7 → 0x008E, error=0 at accept+17. DIV 5/0 → 0xFFFF, error=1 at accept+2. DIV 0xFFFF/0x0001 → 0xFFFF, error=0.
- abort asserted in the 5th MUL cycle → IDLE next edge; no res_valid; res_data retains the previous 0x008E. cmd_valid held during busy is ignored, then accepted the cycle cmd_ready returns.
- Assert reset asynchronously mid-DIV (between edges) → res_data=0, res_error=0, busy=0 immediately. After release, a new ADD 1+1 → 0x0002 at accept+2.
